// File: rtl/romix_pkg.sv
// Shared types and constants for the ROMix loop-index sequencer.
package romix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    MIX  = 2'd2
  } romix_cnt_state_t;

  localparam logic PHASE_FILL  = 1'b0;
  localparam logic PHASE_MIX   = 1'b1;
  localparam int   ROMIX_IDX_W = 5;

endpackage

// File: rtl/romix_index_reg.sv
// Generalised WIDTH-bit up counter with synchronous clear (dominant) and increment.
module romix_index_reg
  import romix_pkg::*;
#(
  parameter int WIDTH = ROMIX_IDX_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/romix_phase_counter.sv
// Programmable-length FILL/MIX index sequencer with last-step flag and done pulse.
module romix_phase_counter
  import romix_pkg::*;
#(
  parameter int WIDTH     = ROMIX_IDX_W,
  parameter bit TWO_PHASE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] index,
  output logic             phase,
  output logic             busy,
  output logic             last,
  output logic             done
);

  romix_cnt_state_t state_q, state_d;
  logic [WIDTH-1:0] limit_q;
  logic             done_d;
  logic             cap_limit;
  logic             idx_clr;
  logic             idx_inc;
  logic             at_limit;

  assign at_limit = (index == limit_q);

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    cap_limit = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cap_limit = 1'b1;
          idx_clr   = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (en) begin
          if (at_limit) begin
            idx_clr = 1'b1;
            state_d = TWO_PHASE ? MIX : IDLE;
            done_d  = ~TWO_PHASE;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      MIX: begin
        if (en) begin
          if (at_limit) begin
            idx_clr = 1'b1;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: begin
        idx_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
    // Abort overrides everything decoded above, including a same-cycle start.
    if (clear) begin
      state_d   = IDLE;
      done_d    = 1'b0;
      cap_limit = 1'b0;
      idx_clr   = 1'b1;
      idx_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      limit_q <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (cap_limit) begin
        limit_q <= limit;
      end
    end
  end

  romix_index_reg #(
    .WIDTH(WIDTH)
  ) u_index (
    .clk(clk),
    .clr(reset | idx_clr),
    .inc(idx_inc),
    .q  (index)
  );

  assign busy  = (state_q != IDLE);
  assign phase = (state_q == MIX) ? PHASE_MIX : PHASE_FILL;
  assign last  = busy & at_limit;

endmodule

// File: doc/romix_phase_counter.md
# romix_phase_counter

Parametrised loop-index sequencer for the ROMix core; it replaces the fixed 5-bit free-running up counter. It runs a programmable-length index through the fill phase (V[i] writes) and then, optionally, the mix phase. It signals the last step of each phase and issues a one-cycle done pulse so the ROMix controller no longer decodes count values itself. The block sits between the ROMix control FSM and the scratchpad address mux.

## Interface
- `WIDTH`, 5: index width; the maximum run length is 2^WIDTH steps per phase.
- `TWO_PHASE`, 1: 1 runs FILL then MIX; 0 runs FILL only.
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begins a run; only honoured in IDLE.
- `en`, in, 1: advances the index by one step; only honoured in FILL or MIX.
- `clear`, in, 1: synchronous abort back to IDLE.
- `limit`, in, WIDTH: last index of each phase (N-1); captured on an accepted `start`.
- `index`, out, WIDTH: current loop index.
- `phase`, out, 1: 0 = FILL, 1 = MIX; 0 in IDLE.
- `busy`, out, 1: high in FILL or MIX.
- `last`, out, 1: combinational; equals `busy & (index == limit_q)`.
- `done`, out, 1: registered one-cycle pulse when a run completes.

## Operation
- States: IDLE, FILL, MIX.
- Priority: `reset` > `clear` > `start` > `en`.
- IDLE with `start`: `limit_q <= limit`, `index <= 0`, state goes to FILL.
- IDLE with `en`: ignored.
- FILL with `en` and `index != limit_q`: `index <= index + 1`.
- FILL with `en` and `index == limit_q`:
  - `TWO_PHASE` = 1: `index <= 0`, state goes to MIX.
  - `TWO_PHASE` = 0: `index <= 0`, state goes to IDLE, `done <= 1`.
- MIX with `en` and `index != limit_q`: `index <= index + 1`.
- MIX with `en` and `index == limit_q`: `index <= 0`, state goes to IDLE, `done <= 1`.
- `done` is cleared on every other cycle; it is never high for two consecutive cycles.
- `start` while busy: ignored; `limit_q` is unchanged.
- `limit` changes mid-run: no effect, because only `limit_q` is compared.
- `clear` in any state: IDLE, `index` = 0, `done` = 0. No done pulse is issued for an aborted run.
- `clear` together with `start`: clear wins; the block stays IDLE.
- `limit` = 0: each phase lasts exactly one `en` step, and `last` is high the whole time the block is busy.
- `limit` = 2^WIDTH-1: the index never wraps through `+1`; the terminal compare catches it first. Arithmetic is unsigned, WIDTH bits wide, and no overflow logic is needed.
- A run consumes exactly (limit+1) `en` steps per phase: 2·(limit+1) when `TWO_PHASE` = 1, (limit+1) when 0.

## Timing
- Reset values: `index` = 0, `phase` = 0, `busy` = 0, `done` = 0, `last` = 0, `limit_q` = 0, state IDLE.
- Accepted `start` in cycle t: `busy` = 1, `phase` = 0, `index` = 0 in cycle t+1.
- The first `en` is honoured in t+1 at the earliest.
- Index update latency: one cycle after the sampled `en`.
- `last` has zero latency relative to `index`. A controller qualifies its final write with `en & last` in the same cycle.
- Final `en` accepted in cycle t: `done` = 1, `busy` = 0, `index` = 0 in cycle t+1.
- A new `start` is accepted in cycle t+1, i.e. back-to-back runs are possible.
- FILL to MIX: `phase` = 1 and `index` = 0 appear together one cycle after the final FILL `en`. There is no bubble cycle.

## Structure
- Shared package `romix_pkg`:
  - state enum `romix_cnt_state_t` (IDLE, FILL, MIX);
  - constants `PHASE_FILL` = 1'b0 and `PHASE_MIX` = 1'b1;
  - default `ROMIX_IDX_W` = 5.
- Sub-module `romix_index_reg`: WIDTH-bit register with synchronous `clr` and `inc` inputs, `clr` dominant. It is the generalised up counter.
- The FSM, the `limit_q` capture and `done` generation live in the top module.

## Test plan
- Reset, then `start` with `limit`=3, `TWO_PHASE`=1, `en` held high:
  - `index` sequence 0,1,2,3,0,1,2,3;
  - `phase` rises with the fifth `index` value;
  - `done` high exactly one cycle after the 8th `en`;
  - `busy` low in that same cycle.
- `TWO_PHASE`=0, `limit`=31, `WIDTH`=5:
  - 32 steps with no wrap glitch;
  - `done` after the 32nd `en`;
  - `phase` stays 0 throughout.
- `limit`=0:
  - `last` high both busy cycles;
  - `done` two cycles after the first accepted `en`.
- `limit` changed from 3 to 1 and a second `start` pulsed during FILL: the run still completes 8 steps, and the second `start` is ignored.
- `clear` at `index`=2 of MIX, with `start` asserted in the same cycle:
  - IDLE next cycle, `index` = 0;
  - no `done` pulse;
  - a later `start` runs normally.
- `en` toggled randomly with 50% duty:
  - `index` advances only on cycles with `en` high;
  - total accepted `en` count at `done` equals 2·(limit+1).
